// File: rtl/mem_reader_pkg.sv
// Shared types and constants for the memory stream reader.
package mem_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = 2;

endpackage

// File: rtl/mem_reader_skid.sv
// Two-entry FIFO that absorbs RAM returns the output register cannot take yet.
module mem_reader_skid
    import mem_reader_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [OCC_W-1:0] o_occ,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;

    // Push/pop bookkeeping; callers never pop an empty or push a full FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= {WIDTH{1'b0}};
            r_tail <= {WIDTH{1'b0}};
            r_occ  <= {OCC_W{1'b0}};
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == OCC_W'(0)) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_occ <= r_occ + OCC_W'(1);
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - OCC_W'(1);
                end
                2'b11: begin
                    if (r_occ == OCC_W'(1)) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_head;

endmodule

// File: rtl/mem_stream_reader.sv
// Streams len words from a 1-cycle-latency RAM onto a valid/ready port.
// Optional MEM_READER_STRIDE_EN adds a per-command address stride.
module mem_stream_reader
    import mem_reader_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 65704,
    parameter  int LEN_W = 17,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LEN_W-1:0] len,
`ifdef MEM_READER_STRIDE_EN
    input  logic [AW-1:0]    stride,
`endif
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_wr_en,
    input  logic [WIDTH-1:0] mem_q,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e           r_state;
    state_e           w_next_state;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_mem_addr;
    logic [LEN_W-1:0] r_remaining;
    logic             r_rd_pend;
    logic             r_q_vld;
    logic             r_busy;
    logic             r_done;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_issue;
    logic             w_finish;
    logic             w_pop_out;
    logic             w_out_free;
    logic             w_room;
    logic [2:0]       w_pending;
    logic [AW-1:0]    w_issue_addr;
    logic [AW-1:0]    w_step;
    logic [OCC_W-1:0] w_skid_occ;
    logic [WIDTH-1:0] w_skid_head;
    logic             w_skid_push;
    logic             w_skid_pop;

`ifdef MEM_READER_STRIDE_EN
    logic [AW-1:0]    r_step;
    assign w_step = (r_state == IDLE) ? stride : r_step;
`else
    assign w_step = AW'(1);
`endif

    assign w_pop_out    = r_out_valid & out_ready;
    assign w_out_free   = ~r_out_valid | w_pop_out;
    assign w_issue_addr = (r_state == IDLE) ? base_addr : r_addr;

    // Words held or still in the RAM pipeline; must never exceed skid plus output register.
    assign w_pending = {1'b0, w_skid_occ} + 3'(r_out_valid) + 3'(r_rd_pend) + 3'(r_q_vld);
    assign w_room    = (w_pending - 3'(w_pop_out)) < 3'(SKID_DEPTH + 1);

    assign w_skid_pop  = w_out_free & (w_skid_occ != OCC_W'(0));
    assign w_skid_push = r_q_vld & ~(w_out_free & (w_skid_occ == OCC_W'(0)));

    mem_reader_skid #(.WIDTH(WIDTH)) u_skid (
        .i_clk  (clock),
        .i_rst  (rst),
        .i_push (w_skid_push),
        .i_pop  (w_skid_pop),
        .i_data (mem_q),
        .o_occ  (w_skid_occ),
        .o_head (w_skid_head)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start && (len == LEN_W'(1))) begin
                    w_next_state = DRAIN;
                end else if (start && (len != {LEN_W{1'b0}})) begin
                    w_next_state = READ;
                end else begin
                    w_next_state = IDLE;
                end
            end
            READ: begin
                if (w_issue && (r_remaining == LEN_W'(1))) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = READ;
                end
            end
            DRAIN: begin
                if (w_finish) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: the accepting edge issues the first read itself.
    always_comb begin
        w_issue  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE: begin
                w_issue  = start & (len != {LEN_W{1'b0}});
                w_finish = start & (len == {LEN_W{1'b0}});
            end
            READ: begin
                w_issue = w_room;
            end
            DRAIN: begin
                w_finish = ~r_rd_pend & ~r_q_vld & (w_skid_occ == OCC_W'(0)) & w_out_free;
            end
            default: begin
                w_issue  = 1'b0;
                w_finish = 1'b0;
            end
        endcase
    end

    // Address/length counters, read pipeline tracking and the output register.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_addr      <= {AW{1'b0}};
            r_mem_addr  <= {AW{1'b0}};
            r_remaining <= {LEN_W{1'b0}};
            r_rd_pend   <= 1'b0;
            r_q_vld     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
`ifdef MEM_READER_STRIDE_EN
            r_step      <= {AW{1'b0}};
`endif
        end else begin
            r_rd_pend <= w_issue;
            r_q_vld   <= r_rd_pend;
            r_busy    <= (w_next_state != IDLE);
            r_done    <= w_finish;
            if (w_issue) begin
                r_mem_addr  <= w_issue_addr;
                r_addr      <= w_issue_addr + w_step;
                r_remaining <= (r_state == IDLE) ? (len - LEN_W'(1)) : (r_remaining - LEN_W'(1));
            end
`ifdef MEM_READER_STRIDE_EN
            if ((r_state == IDLE) && start) begin
                r_step <= stride;
            end
`endif
            // Skid head has priority so order is preserved; bypass only when it is empty.
            if (w_out_free) begin
                if (w_skid_occ != OCC_W'(0)) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_skid_head;
                end else if (r_q_vld) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= mem_q;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_addr  = r_mem_addr;
    assign mem_wr_en = 1'b0;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
